// File: rtl/demux4_router_if.sv
// Stream bundle for demux4_router: one valid/ready input, four buffered outputs.
// Counter signals exist only when DEMUX4_ROUTER_STATS_EN is defined.
interface demux4_router_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_sel;
  logic [WIDTH-1:0] in_data;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [WIDTH-1:0] out_data0;
  logic [WIDTH-1:0] out_data1;
  logic [WIDTH-1:0] out_data2;
  logic [WIDTH-1:0] out_data3;
`ifdef DEMUX4_ROUTER_STATS_EN
  logic [15:0]      out_count0;
  logic [15:0]      out_count1;
  logic [15:0]      out_count2;
  logic [15:0]      out_count3;

  modport master (
    output flush, in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3,
    input  out_count0, out_count1, out_count2, out_count3
  );
  modport slave (
    input  flush, in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3,
    output out_count0, out_count1, out_count2, out_count3
  );
`else
  modport master (
    output flush, in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3
  );
  modport slave (
    input  flush, in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3
  );
`endif
endinterface

// File: rtl/demux4_router.sv
// demux4_router: routes one valid/ready stream to four channels, each with a one-entry holding register.
// Define DEMUX4_ROUTER_STATS_EN to build the per-channel 16-bit delivered-word counters.
module demux4_router #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            reset,
  demux4_router_if.slave bus
);
  logic [3:0] full_q;
  logic [3:0] full_d;
  logic [3:0] accept;
  logic [3:0] drain;
  logic       in_ready;

  // A full channel can still accept when its consumer drains in the same cycle.
  always_comb begin
    in_ready = !reset && !bus.flush &&
               (!full_q[bus.in_sel] || bus.out_ready[bus.in_sel]);
    accept = 4'b0000;
    if (bus.in_valid && in_ready) begin
      accept[bus.in_sel] = 1'b1;
    end
    drain  = full_q & bus.out_ready;
    full_d = bus.flush ? 4'b0000 : ((full_q & ~drain) | accept);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 4'b0000;
    end else begin
      full_q <= full_d;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_chan
      logic [WIDTH-1:0] buf_q;
      logic [WIDTH-1:0] buf_d;

      // Flush leaves the data register alone; only the full bit is cleared.
      always_comb begin
        buf_d = accept[gi] ? bus.in_data : buf_q;
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          buf_q <= '0;
        end else begin
          buf_q <= buf_d;
        end
      end

`ifdef DEMUX4_ROUTER_STATS_EN
      logic [15:0] count_q;
      logic [15:0] count_d;

      // Handshakes in a flush cycle still count; wrap is natural 16-bit overflow.
      always_comb begin
        count_d = count_q + {15'd0, drain[gi]};
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          count_q <= 16'h0000;
        end else begin
          count_q <= count_d;
        end
      end
`endif
    end
  endgenerate

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = full_q;
  assign bus.out_data0 = g_chan[0].buf_q;
  assign bus.out_data1 = g_chan[1].buf_q;
  assign bus.out_data2 = g_chan[2].buf_q;
  assign bus.out_data3 = g_chan[3].buf_q;
`ifdef DEMUX4_ROUTER_STATS_EN
  assign bus.out_count0 = g_chan[0].count_q;
  assign bus.out_count1 = g_chan[1].count_q;
  assign bus.out_count2 = g_chan[2].count_q;
  assign bus.out_count3 = g_chan[3].count_q;
`endif
endmodule
